lstm_mac_accum: RTL and testbench

- Fixed-point multiply-accumulate stage directly downstream of the LSTM 3-input operand multiplexer.
- Each accepted beat multiplies the selected operand by a weight/delta and accumulates LEN products into one dot-product result.
- The result is saturated to WIDTH and held on a valid/ack handshake for the gate/error-update logic.
- One instance per gate lane in the forward and backprop datapaths.

---
 rtl/lstm_pkg.sv | 26 ++
 rtl/lstm_sat_trunc.sv | 31 +++
 rtl/lstm_mac_accum.sv | 145 ++++++++++++++
 tb/tb_lstm_mac_accum.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lstm_pkg.sv
// Shared definitions for the LSTM datapath blocks: FSM state encoding,
// default fixed-point format, accumulator guard bits and saturation limits.
package lstm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_FRAC   = 24;
    localparam int GUARD_BITS = 8;

    // Largest positive two's complement value of the given width (zero-extended)
    function automatic logic [63:0] sat_max(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    // Bit pattern of the most negative two's complement value of the given width
    function automatic logic [63:0] sat_min(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/lstm_sat_trunc.sv
// Combinational clip of a wide signed value down to WIDTH bits, flagging
// whenever the value did not fit.  Shared by the MAC and gate-update stages.
module lstm_sat_trunc
    import lstm_pkg::*;
#(
    parameter int IN_W  = DEF_WIDTH + GUARD_BITS,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [IN_W-1:0]  din,
    output logic [WIDTH-1:0] dout,
    output logic             sat
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(sat_min(WIDTH));

    // Everything from the result sign bit upward must agree for the value to fit
    logic [IN_W-WIDTH:0] upper;
    assign upper = din[IN_W-1:WIDTH-1];

    // Pass the low bits through, or clip toward the sign of the wide input
    always_comb begin
        dout = din[WIDTH-1:0];
        sat  = 1'b0;
        if (!((&upper) || !(|upper))) begin
            sat  = 1'b1;
            dout = din[IN_W-1] ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/lstm_mac_accum.sv
// Fixed-point multiply-accumulate stage for one LSTM gate lane.
// Accepts LEN operand/weight beats, accumulates the FRAC-aligned products
// and presents the saturated dot product on a valid/ack handshake.
// Optional build macro LSTM_MAC_ROUND_EN: round each product half toward
// +inf before dropping the fractional bits (default build truncates).
module lstm_mac_accum
    import lstm_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int FRAC  = DEF_FRAC,
    parameter int LEN   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_w,
    output logic             o_valid,
    input  logic             i_ack,
    output logic [WIDTH-1:0] o,
    output logic             o_sat
);

    localparam int CW = $clog2(LEN) + 1;
    localparam int PW = WIDTH + FRAC;
    // Product magnitude needs 2*WIDTH-FRAC bits; guard bits cover up to 256 terms
    localparam int AW = 2 * WIDTH - FRAC + GUARD_BITS;
    localparam logic [CW-1:0] LAST_IDX = CW'(LEN - 1);

    state_t state, state_next;
    logic [CW-1:0] count;
    logic accept, first_beat, last_beat;

    logic signed [2*WIDTH-1:0] a_ext, w_ext, prod_full, prod_adj;
    logic signed [PW-1:0] prod_aligned;

    logic p_valid, p_first;
    logic signed [PW-1:0] p_prod;
    logic signed [AW-1:0] p_ext, acc, acc_next;

    logic [WIDTH-1:0] sat_val;
    logic sat_flag;

    assign accept     = i_valid && o_ready;
    assign first_beat = (count == '0);
    assign last_beat  = (count == LAST_IDX);

    assign a_ext     = (2*WIDTH)'($signed(i_a));
    assign w_ext     = (2*WIDTH)'($signed(i_w));
    assign prod_full = a_ext * w_ext;

`ifdef LSTM_MAC_ROUND_EN
    localparam logic [2*WIDTH-1:0] RND_HALF = (2*WIDTH)'(1) << (FRAC - 1);
    assign prod_adj = prod_full + $signed(RND_HALF);
`else
    assign prod_adj = prod_full;
`endif

    assign prod_aligned = PW'(prod_adj >>> FRAC);
    assign p_ext        = AW'(p_prod);
    assign acc_next     = p_first ? p_ext : acc + p_ext;

    lstm_sat_trunc #(
        .IN_W  (AW),
        .WIDTH (WIDTH)
    ) u_sat (
        .din  (acc_next),
        .dout (sat_val),
        .sat  (sat_flag)
    );

    // Handshake outputs and next state; ready never looks at i_valid
    always_comb begin
        state_next = state;
        o_ready    = 1'b0;
        o_valid    = 1'b0;
        case (state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) state_next = ACC;
            end
            ACC: begin
                o_ready = 1'b1;
                if (i_valid && last_beat) state_next = DRAIN;
            end
            DRAIN: begin
                state_next = HOLD;
            end
            HOLD: begin
                o_valid = 1'b1;
                o_ready = i_ack;
                if (i_ack) state_next = i_valid ? ACC : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register and element counter; counter wraps to 0 after the last beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            if (accept) count <= last_beat ? '0 : count + CW'(1);
        end
    end

    // Stage 1: register the aligned product and whether it opens a new sum
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_valid <= 1'b0;
            p_first <= 1'b0;
            p_prod  <= '0;
        end else begin
            p_valid <= accept;
            if (accept) begin
                p_prod  <= prod_aligned;
                p_first <= first_beat;
            end
        end
    end

    // Stage 2: accumulate; the first product of a dot product loads instead of adding
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (p_valid) begin
            acc <= acc_next;
        end
    end

    // Capture the clipped final sum as the last product lands, held through HOLD
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o     <= '0;
            o_sat <= 1'b0;
        end else if (state == DRAIN) begin
            o     <= sat_val;
            o_sat <= sat_flag;
        end
    end

endmodule

// File: tb/tb_lstm_mac_accum.sv
// Scoreboard bench for lstm_mac_accum with LEN=4, Q7.24 operands.
// The driver feeds beats and a plain-arithmetic dot-product model pushes the
// expected result; an independent monitor compares whenever o_valid is high.
`timescale 1ns/1ps
module tb_lstm_mac_accum;

    localparam int WIDTH = 32;
    localparam int FRAC  = 24;
    localparam int LEN   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_valid = 1'b0;
    logic i_ack = 1'b0;
    logic [WIDTH-1:0] i_a = '0;
    logic [WIDTH-1:0] i_w = '0;
    logic o_ready, o_valid, o_sat;
    logic [WIDTH-1:0] o;

    lstm_mac_accum #(.WIDTH(WIDTH), .FRAC(FRAC), .LEN(LEN)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_a     (i_a),
        .i_w     (i_w),
        .o_valid (o_valid),
        .i_ack   (i_ack),
        .o       (o),
        .o_sat   (o_sat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] val;
        logic        sat;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    longint cur_sum = 0;
    int cur_n = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Real-valued product scaled by 2^FRAC, rounded or floored to an integer
    function automatic longint alignedProduct(input logic [31:0] a, input logic [31:0] w);
        longint p;
        p = longint'($signed(a)) * longint'($signed(w));
`ifdef LSTM_MAC_ROUND_EN
        p = p + (longint'(1) <<< (FRAC - 1));
`endif
        return p >>> FRAC;
    endfunction

    // Accumulate one accepted beat; after LEN beats queue the saturated result
    task automatic modelBeat(input logic [31:0] a, input logic [31:0] w, input int acc_cyc);
        exp_t e;
        logic [63:0] bits;
        longint maxv = 64'sd2147483647;
        longint minv = -64'sd2147483648;
        cur_sum += alignedProduct(a, w);
        cur_n++;
        if (cur_n == LEN) begin
            bits = cur_sum;
            if (cur_sum > maxv) begin
                e.val = 32'h7FFF_FFFF;
                e.sat = 1'b1;
            end else if (cur_sum < minv) begin
                e.val = 32'h8000_0000;
                e.sat = 1'b1;
            end else begin
                e.val = bits[31:0];
                e.sat = 1'b0;
            end
            e.cyc = acc_cyc + 2;
            sb.push_back(e);
            cur_sum = 0;
            cur_n = 0;
        end
    endtask

    function automatic logic [31:0] rndVal();
        int v;
        if ($urandom_range(0, 3) == 0) return $urandom;
        v = int'($urandom_range(0, 32'h0800_0000)) - 32'h0400_0000;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat that must be accepted at the next rising edge
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] w);
        i_valid = 1'b1;
        i_a = a;
        i_w = w;
        @(negedge clk);
        checkOutput("ready_accept", o_ready, 1);
        modelBeat(a, w, cyc);
        step();
        i_valid = 1'b0;
        i_a = $urandom;
        i_w = $urandom;
    endtask

    task automatic applyReset();
        rst = 1'b1;
        i_valid = 1'b0;
        i_ack = 1'b0;
        cur_sum = 0;
        cur_n = 0;
        @(negedge clk);
        checkOutput("reset_ready", o_ready, 1);
        checkOutput("reset_valid", o_valid, 0);
        checkOutput("reset_o", o, 0);
        checkOutput("reset_sat", o_sat, 0);
        step();
        rst = 1'b0;
    endtask

    // Wait for the result while offering junk beats that must be refused
    task automatic waitResult();
        int k = 0;
        bit got = 0;
        i_ack = 1'b0;
        while (k < 20 && !got) begin
            i_valid = 1'b1;
            i_a = $urandom;
            i_w = $urandom;
            @(negedge clk);
            checkOutput("ready_blocked", o_ready, 0);
            if (o_valid) got = 1;
            step();
            k++;
        end
        i_valid = 1'b0;
        if (!got) checkOutput("result_timeout", 0, 1);
    endtask

    // Keep the result pending for hold cycles, then ack (optionally with a new beat)
    task automatic ackResult(input int hold, input bit with_beat, input logic [31:0] a, input logic [31:0] w);
        repeat (hold) begin
            i_valid = 1'b1;
            i_ack = 1'b0;
            i_a = $urandom;
            i_w = $urandom;
            @(negedge clk);
            checkOutput("ready_hold", o_ready, 0);
            checkOutput("valid_hold", o_valid, 1);
            step();
        end
        i_ack = 1'b1;
        i_valid = with_beat;
        i_a = a;
        i_w = w;
        @(negedge clk);
        checkOutput("ready_ack", o_ready, 1);
        if (with_beat) modelBeat(a, w, cyc);
        step();
        i_ack = 1'b0;
        i_valid = 1'b0;
    endtask

    // Monitor: check the pending result every cycle it is shown, pop on ack
    initial begin
        bit prev_v = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v = 0;
            end else begin
                if (o_valid) begin
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_result", 1, 0);
                    end else begin
                        if (!prev_v) checkOutput("latency_cycle", cyc, sb[0].cyc);
                        checkOutput("result_o", o, sb[0].val);
                        checkOutput("result_sat", o_sat, sb[0].sat);
                        if (i_ack) void'(sb.pop_front());
                    end
                end
                prev_v = o_valid;
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyReset();

        // Mixed-sign dot product: 1*1 + 2*0.5 + (-1)*3 + 0.5*0.5
        applyStimulus(32'h0100_0000, 32'h0100_0000);
        applyStimulus(32'h0200_0000, 32'h0080_0000);
        applyStimulus(32'hFF00_0000, 32'h0300_0000);
        applyStimulus(32'h0080_0000, 32'h0080_0000);
        waitResult();
        ackResult(0, 0, 0, 0);

        // Positive and negative saturation
        repeat (LEN) applyStimulus(32'h7F00_0000, 32'h7F00_0000);
        waitResult();
        ackResult(0, 0, 0, 0);
        repeat (LEN) applyStimulus(32'h8100_0000, 32'h7F00_0000);
        waitResult();
        ackResult(0, 0, 0, 0);

        // Long hold with valid asserted, then ack together with element 0
        repeat (LEN) applyStimulus(32'h0100_0000, 32'h0040_0000);
        waitResult();
        ackResult(5, 1, 32'h0200_0000, 32'h0100_0000);
        for (int b = 1; b < LEN; b++) applyStimulus(32'h0100_0000, 32'h0100_0000);
        waitResult();
        ackResult(0, 0, 0, 0);

        // Partial sum discarded by a mid-operation reset
        applyStimulus(32'h0700_0000, 32'h0700_0000);
        applyStimulus(32'h0700_0000, 32'h0700_0000);
        applyReset();
        repeat (LEN) applyStimulus(32'h0100_0000, 32'h0100_0000);
        waitResult();
        ackResult(1, 0, 0, 0);

        // Sub-LSB products: truncated to 0, or rounded up to 1 each
        repeat (LEN) applyStimulus(32'h0000_0001, 32'h0080_0000);
        waitResult();
        ackResult(0, 0, 0, 0);

        // Random operands with ~50% gaps, back-to-back via ack-with-beat
        for (int d = 0; d < 10; d++) begin
            for (int b = (d == 0) ? 0 : 1; b < LEN; b++) begin
                for (int g = 0; g < 4 && $urandom_range(0, 1) == 1; g++) step();
                applyStimulus(rndVal(), rndVal());
            end
            waitResult();
            if (d < 9) ackResult($urandom_range(0, 2), 1, rndVal(), rndVal());
            else ackResult(0, 0, 0, 0);
        end

        repeat (3) step();
        checkOutput("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
